// File: rtl/ws281x_bit_gen.sv
// WS281x line encoder: turns bit / latch tokens into timed high-low waveforms on the LED data pin.
// A one-entry holding register lets the next token start on the cycle right after the current one ends.
module ws281x_bit_gen #(
  parameter int CNT_W = 8,
  parameter int RST_W = 16,
  parameter bit INV   = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             bit_vld_in,
  output logic             bit_rdy_out,
  input  logic             bit_data_in,
  input  logic             rst_req_in,
  input  logic [CNT_W-1:0] t0h_cnt_in,
  input  logic [CNT_W-1:0] t0s_cnt_in,
  input  logic [CNT_W-1:0] t1h_cnt_in,
  input  logic [CNT_W-1:0] t1s_cnt_in,
  input  logic [RST_W-1:0] rst_cnt_in,
  output logic             dout_out,
  output logic             bit_done_out,
  output logic             busy_out
);
  localparam int W = (CNT_W > RST_W) ? CNT_W : RST_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_RST  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_cnt, w_cnt_nxt;
  logic [W-1:0]     r_lo, w_lo_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_hold_rst;
  logic [CNT_W-1:0] r_hold_hi;
  logic [W-1:0]     r_hold_lo;
  logic             r_dout;

  logic [CNT_W-1:0] w_ts, w_th, w_p, w_new_hi;
  logic [W-1:0]     w_new_lo;
  logic             w_acc, w_last, w_hold_cap;
  logic             w_ld, w_ld_rst;
  logic [CNT_W-1:0] w_ld_hi;
  logic [W-1:0]     w_ld_lo;

  // Incoming token reduced to {reset?, high cycles, low cycles}; a reset code is all low.
  always_comb begin
    w_ts     = bit_data_in ? t1s_cnt_in : t0s_cnt_in;
    w_th     = bit_data_in ? t1h_cnt_in : t0h_cnt_in;
    w_p      = (w_ts == '0) ? CNT_W'(1) : w_ts;
    w_new_hi = rst_req_in ? '0 : ((w_th > w_p) ? w_p : w_th);
    if (rst_req_in)
      w_new_lo = (rst_cnt_in == '0) ? W'(1) : W'(rst_cnt_in);
    else
      w_new_lo = W'(w_p - w_new_hi);
  end

  assign w_acc  = bit_vld_in && !r_hold_full;
  assign w_last = (r_state == S_HIGH) ? ((r_cnt == W'(1)) && (r_lo == '0))
                                      : ((r_state != S_IDLE) && (r_cnt == W'(1)));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lo        <= '0;
      r_hold_full <= 1'b0;
      r_hold_rst  <= 1'b0;
      r_hold_hi   <= '0;
      r_hold_lo   <= '0;
      r_dout      <= INV;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lo        <= w_lo_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_dout      <= (w_state_nxt == S_HIGH) ^ INV;
      if (w_hold_cap) begin
        r_hold_rst <= rst_req_in;
        r_hold_hi  <= w_new_hi;
        r_hold_lo  <= w_new_lo;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lo_nxt        = r_lo;
    w_hold_full_nxt = r_hold_full;
    w_hold_cap      = 1'b0;
    w_ld            = 1'b0;
    w_ld_rst        = rst_req_in;
    w_ld_hi         = w_new_hi;
    w_ld_lo         = w_new_lo;
    if (r_state == S_IDLE) begin
      w_ld = w_acc;
    end else if (w_last) begin
      // Held token has priority; the hold register is never full while a new token is accepted.
      if (r_hold_full) begin
        w_ld            = 1'b1;
        w_ld_rst        = r_hold_rst;
        w_ld_hi         = r_hold_hi;
        w_ld_lo         = r_hold_lo;
        w_hold_full_nxt = 1'b0;
      end else if (w_acc) begin
        w_ld = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_lo_nxt    = '0;
      end
    end else begin
      if ((r_state == S_HIGH) && (r_cnt == W'(1))) begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = r_lo;
        w_lo_nxt    = '0;
      end else begin
        w_cnt_nxt = r_cnt - W'(1);
      end
      if (w_acc) begin
        w_hold_full_nxt = 1'b1;
        w_hold_cap      = 1'b1;
      end
    end
    if (w_ld) begin
      if (w_ld_rst) begin
        w_state_nxt = S_RST;
        w_cnt_nxt   = w_ld_lo;
        w_lo_nxt    = '0;
      end else if (w_ld_hi != '0) begin
        w_state_nxt = S_HIGH;
        w_cnt_nxt   = W'(w_ld_hi);
        w_lo_nxt    = w_ld_lo;
      end else begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = w_ld_lo;
        w_lo_nxt    = '0;
      end
    end
  end

  always_comb begin
    bit_rdy_out  = !r_hold_full;
    busy_out     = (r_state != S_IDLE) || r_hold_full;
    bit_done_out = w_last;
    dout_out     = r_dout;
  end

endmodule

// File: tb/tb_ws281x_bit_gen.sv
// Scoreboard bench for ws281x_bit_gen: the driver queues hand-computed high/low cycle counts per token,
// the monitor measures each token on the line and checks it when bit_done_out pulses.
module tb_ws281x_bit_gen;
  localparam int CNT_W = 8;
  localparam int RST_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, bit_vld, bit_data, rst_req;
  logic [CNT_W-1:0] t0h, t0s, t1h, t1s;
  logic [RST_W-1:0] rst_cnt;
  logic bit_rdy, dout, done, busy;
  logic bit_rdy_i, dout_i, done_i, busy_i;

  ws281x_bit_gen #(.CNT_W(CNT_W), .RST_W(RST_W), .INV(1'b0)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .bit_vld_in(bit_vld), .bit_rdy_out(bit_rdy),
    .bit_data_in(bit_data), .rst_req_in(rst_req),
    .t0h_cnt_in(t0h), .t0s_cnt_in(t0s), .t1h_cnt_in(t1h), .t1s_cnt_in(t1s),
    .rst_cnt_in(rst_cnt), .dout_out(dout), .bit_done_out(done), .busy_out(busy)
  );

  ws281x_bit_gen #(.CNT_W(CNT_W), .RST_W(RST_W), .INV(1'b1)) u_dut_inv (
    .clk_in(clk), .rst_n_in(rst_n), .bit_vld_in(bit_vld), .bit_rdy_out(bit_rdy_i),
    .bit_data_in(bit_data), .rst_req_in(rst_req),
    .t0h_cnt_in(t0h), .t0s_cnt_in(t0s), .t1h_cnt_in(t1h), .t1s_cnt_in(t1s),
    .rst_cnt_in(rst_cnt), .dout_out(dout_i), .bit_done_out(done_i), .busy_out(busy_i)
  );

  typedef struct {
    int hi;
    int lo;
    bit btb;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: measures each token between bit_done pulses and compares against the queue.
  int   m_hi = 0, m_lo = 0;
  bit   m_in_tok = 0, m_prev_done = 0, m_start_btb = 0, m_order_err = 0;
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_in_tok = 0; m_prev_done = 0; m_order_err = 0;
    end else begin
      check("inv_twin", {dout_i, done_i, busy_i, bit_rdy_i}, {~dout, done, busy, bit_rdy});
      if (busy) begin
        if (!m_in_tok) begin
          m_in_tok    = 1;
          m_start_btb = m_prev_done;
        end
        if (dout) begin
          if (m_lo != 0) m_order_err = 1;
          m_hi++;
        end else begin
          m_lo++;
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_token", 1, 0);
          end else begin
            m_e = sb.pop_front();
            check("tok_high_cycles", m_hi, m_e.hi);
            check("tok_low_cycles", m_lo, m_e.lo);
            check("tok_abuts_prev", int'(m_start_btb), int'(m_e.btb));
            check("tok_high_then_low", int'(m_order_err), 0);
          end
          m_in_tok = 0; m_hi = 0; m_lo = 0; m_order_err = 0;
        end
      end else begin
        check("idle_level", {dout, done}, 2'b00);
      end
      m_prev_done = done;
    end
  end

  task automatic send(input bit d, input bit r, input int rl, input int eh, input int el, input bit eb);
    int   waitc;
    exp_t e;
    @(negedge clk);
    bit_data = d;
    rst_req  = r;
    rst_cnt  = RST_W'(rl);
    bit_vld  = 1'b1;
    waitc    = 0;
    while (!bit_rdy && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!bit_rdy) begin
      check("accept_timeout", 0, 1);
      bit_vld = 1'b0;
    end else begin
      e.hi = eh; e.lo = el; e.btb = eb;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int c;
    @(negedge clk);
    bit_vld = 1'b0;
    c = 0;
    while ((sb.size() != 0 || busy) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("drain_queue", sb.size(), 0);
    check("drain_busy", int'(busy), 0);
  endtask

  int done_cyc, fall_cyc, n_done;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; bit_vld = 1'b0; bit_data = 1'b0; rst_req = 1'b0; rst_cnt = '0;
    t0h = 8'd2; t0s = 8'd6; t1h = 8'd3; t1s = 8'd8;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_dout_inv", int'(dout_i), 1);
    check("rst_rdy", int'(bit_rdy), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) begin
      @(negedge clk);
      check("idle_rdy", int'(bit_rdy), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_dout", int'(dout), 0);
    end

    // Single 1 bit: 3 high, 5 low, done in cycle 8, busy falls in cycle 9
    send(1, 0, 0, 3, 5, 0);
    done_cyc = 0; fall_cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bit_vld = 1'b0;
      if (done && done_cyc == 0) done_cyc = k;
      if (!busy && fall_cyc == 0) fall_cyc = k;
    end
    check("single_done_cycle", done_cyc, 8);
    check("single_busy_fall", fall_cyc, 9);

    // Back-to-back 1,0,1
    t0h = 8'd2; t0s = 8'd6; t1h = 8'd4; t1s = 8'd6;
    send(1, 0, 0, 4, 2, 0);
    send(0, 0, 0, 2, 4, 1);
    @(negedge clk);
    check("b2b_stall_rdy", int'(bit_rdy), 0);
    send(1, 0, 0, 4, 2, 1);
    drain();

    // Bit then 50-cycle reset code
    send(0, 0, 0, 2, 4, 0);
    send(0, 1, 50, 0, 50, 1);
    drain();
    // High clamped to period
    t1h = 8'd9; t1s = 8'd5;
    send(1, 0, 0, 5, 0, 0);
    drain();
    // Zero period -> single low cycle
    t0h = 8'd0; t0s = 8'd0;
    send(0, 0, 0, 0, 1, 0);
    drain();
    // Zero reset length -> one cycle
    send(0, 1, 0, 0, 1, 0);
    drain();
    // Zero high time -> full low bit
    t0h = 8'd0; t0s = 8'd4;
    send(0, 0, 0, 0, 4, 0);
    drain();

    // Config change after acceptance keeps captured timing
    t1h = 8'd3; t1s = 8'd8;
    send(1, 0, 0, 3, 5, 0);
    @(negedge clk);
    bit_vld = 1'b0;
    @(negedge clk);
    t1h = 8'd6; t1s = 8'd10;
    drain();

    // Reset mid-HIGH with a held token pending
    t1h = 8'd5; t1s = 8'd8; t0h = 8'd2; t0s = 8'd6;
    send(1, 0, 0, 5, 3, 0);
    send(0, 0, 0, 2, 4, 1);
    #2;
    bit_vld = 1'b0;
    check("pre_rst_hold_full", int'(bit_rdy), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", int'(dout), 0);
    check("midrst_dout_inv", int'(dout_i), 1);
    check("midrst_rdy", int'(bit_rdy), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("held_token_dropped", n_done, 0);
    check("final_queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
